// File: rtl/dmem_bus.sv
// dmem_bus: single-port 32-bit data memory behind a request/response bus.
// After reset the memory is cleared one word per cycle. It then accepts
// byte, half and word loads and stores, with a configurable number of wait
// cycles before each response.
//
// Handshake: a request is accepted on a rising edge where req=1 and ready=1.
// ready is high only while idle, so req is ignored at all other times. Every
// accepted request, whether load, store or error, produces exactly one
// rvalid pulse. rdata and err are meaningful only while rvalid=1 and are 0
// otherwise.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req, we        request strobe, 1=store / 0=load
//   addr           byte address (ADDR_W bits)
//   size           00=byte, 01=half, 10=word, 11=illegal
//   uns            1=zero-extend sub-word loads, 0=sign-extend
//   wdata          store data, low-aligned
//   ready          request can be accepted this cycle
//   rvalid         one-cycle response pulse
//   rdata, err     load data / error flag, valid with rvalid
//   init_done      clear sweep has finished
//   fsm_state      current FSM state (INIT=0, IDLE=1, WAIT=2, RESP=3)
module dmem_bus #(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              init_done,
  output logic [1:0]        fsm_state
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_idx;
  logic [3:0]        wait_cnt;

  // Request fields captured at accept, used when the access happens later.
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [1:0]        l_size;
  logic              l_uns;
  logic [31:0]       l_wdata;

  logic [31:0] mem [DEPTH];

  // With no wait cycles the access happens on the accept edge itself, so the
  // live inputs are used; otherwise the latched copy is used.
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [1:0]        a_size;
  logic              a_uns;
  logic [31:0]       a_wdata;
  logic [IDX_W-1:0]  a_idx;
  logic              do_access;
  logic              bad;
  logic [31:0]       cur_word;
  logic [31:0]       st_word;
  logic [31:0]       ld_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       mem_din;

  assign fsm_state = state;

  always_comb begin
    a_we    = l_we;
    a_addr  = l_addr;
    a_size  = l_size;
    a_uns   = l_uns;
    a_wdata = l_wdata;
    if (state == S_IDLE) begin
      a_we    = we;
      a_addr  = addr;
      a_size  = size;
      a_uns   = uns;
      a_wdata = wdata;
    end
  end

  // The access edge is the one that enters RESP.
  assign do_access = ((state == S_IDLE) && req && (WAIT_CYC == 0)) ||
                     ((state == S_WAIT) && (wait_cnt == 4'd0));

  assign a_idx    = a_addr[ADDR_W-1:2];
  assign cur_word = mem[a_idx];

  always_comb begin
    bad = 1'b0;
    case (a_size)
      2'b01:   bad = a_addr[0];
      2'b10:   bad = (a_addr[1:0] != 2'b00);
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
  end

  // Store merge: only the addressed lanes change.
  always_comb begin
    st_word = cur_word;
    case (a_size)
      2'b00:   st_word[{a_addr[1:0], 3'b000} +: 8] = a_wdata[7:0];
      2'b01:   st_word[{a_addr[1], 4'b0000} +: 16] = a_wdata[15:0];
      default: st_word = a_wdata;
    endcase
  end

  assign ld_byte = cur_word[{a_addr[1:0], 3'b000} +: 8];
  assign ld_half = cur_word[{a_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (a_size)
      2'b00:   ld_word = a_uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_word = a_uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_word = cur_word;
    endcase
  end

  // Reset forces INIT asynchronously, so an access still in WAIT can never
  // reach its write.
  assign mem_we  = (state == S_INIT) || (do_access && a_we && !bad);
  assign mem_idx = (state == S_INIT) ? clr_idx : a_idx;
  assign mem_din = (state == S_INIT) ? 32'd0 : st_word;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      clr_idx   <= '0;
      wait_cnt  <= 4'd0;
      ready     <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= 32'd0;
      err       <= 1'b0;
      init_done <= 1'b0;
      l_we      <= 1'b0;
      l_addr    <= '0;
      l_size    <= 2'b00;
      l_uns     <= 1'b0;
      l_wdata   <= 32'd0;
    end else begin
      rvalid <= 1'b0;
      rdata  <= 32'd0;
      err    <= 1'b0;
      case (state)
        S_INIT: begin
          clr_idx <= clr_idx + 1'b1;
          if (&clr_idx) begin
            state     <= S_IDLE;
            ready     <= 1'b1;
            init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req) begin
            l_we    <= we;
            l_addr  <= addr;
            l_size  <= size;
            l_uns   <= uns;
            l_wdata <= wdata;
            ready   <= 1'b0;
            if (WAIT_CYC == 0) begin
              state <= S_RESP;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= 4'(WAIT_CYC - 1);
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_RESP: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: state <= S_INIT;
      endcase
      if (do_access) begin
        rvalid <= 1'b1;
        err    <= bad;
        rdata  <= (bad || a_we) ? 32'd0 : ld_word;
      end
    end
  end

endmodule

// File: doc/dmem_bus.md
DMEM_BUS -- requirements
Module: dmem_bus

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; memory depth DEPTH = 2**(ADDR_W-2) 32-bit words.
REQ-002 Parameter WAIT_CYC, default 0, extra wait cycles per access, legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  access request; sampled only while ready=1.
REQ-006 we  input  1  1=store, 0=load.
REQ-007 addr  input  ADDR_W  byte address.
REQ-008 size  input  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-009 uns  input  1  1=zero-extend sub-word loads, 0=sign-extend.
REQ-010 wdata  input  32  store data; the low bits carry the byte or half.
REQ-011 ready  output  1  block can accept a request this cycle.
REQ-012 rvalid  output  1  one-cycle response pulse, for loads and stores.
REQ-013 rdata  output  32  load result, valid while rvalid=1.
REQ-014 err  output  1  error flag, valid while rvalid=1.
REQ-015 init_done  output  1  memory clear sweep has completed.

Function
REQ-016 FSM states: INIT, IDLE, WAIT, RESP.
REQ-017 INIT: clear one word per cycle, index 0..DEPTH-1 ascending.
REQ-018 INIT exit: after the edge that clears word DEPTH-1 -> IDLE, init_done=1; INIT lasts exactly DEPTH cycles.
REQ-019 ready=1 only in IDLE; req is ignored in INIT, WAIT and RESP.
REQ-020 Accept: req=1 and ready=1 at an edge; latch we, addr, size, uns and wdata.
REQ-021 Next state after accept: WAIT if WAIT_CYC>0, else RESP; WAIT holds exactly WAIT_CYC cycles, counted by a 4-bit down-counter.
REQ-022 Access: memory write and read capture occur on the edge entering RESP.
REQ-023 RESP: lasts one cycle with rvalid=1, then IDLE; load-to-rvalid latency = WAIT_CYC+1 cycles; minimum request spacing = WAIT_CYC+2 cycles.
REQ-024 Word index = addr[ADDR_W-1:2]; byte lanes are little-endian, with lane n = bits 8n+7:8n.
REQ-025 Byte store writes lane addr[1:0] with wdata[7:0]; other lanes are unchanged.
REQ-026 Half store writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
REQ-027 Word store writes all four lanes.
REQ-028 Loads extract the same lane(s), extended to 32 bits per uns (sign or zero).
REQ-029 Error conditions: half access with addr[0]=1; word access with addr[1:0]!=0; size=11.
REQ-030 Error response: err=1 with rvalid, rdata=0, and no memory modification.
REQ-031 Store response: rdata=0 and err=0 with rvalid.
REQ-032 Outside RESP: rvalid=0, err=0 and rdata=0.
REQ-033 Address aliasing: none; every ADDR_W-bit address maps to one word of DEPTH.

Reset
REQ-034 rst=1 immediately forces: state INIT, clear index 0, ready=0, rvalid=0, rdata=0, err=0, init_done=0.
REQ-035 Reset mid-access: an access whose RESP-entry edge has not occurred is discarded; no write is performed.
REQ-036 After rst deasserts, the full INIT sweep reruns, so all words read 0 afterwards.
REQ-037 Reset asserted during INIT restarts the sweep from index 0.

Verification
REQ-038 Release reset, DEPTH=64 -> ready=0 and init_done=0 for 64 cycles, then ready=1, init_done=1; word load from any address -> 0x00000000.
REQ-039 Word store 0x80FF7F01 @0x10, then byte loads @0x10..0x13: uns=0 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; uns=1 on @0x12 -> 0x000000FF.
REQ-040 Half store 0xBEEF @0x22, then word load @0x20 -> 0xBEEF0000; half load @0x22 with uns=0 -> 0xFFFFBEEF.
REQ-041 Word store @0x05, half load @0x03, size=11 access -> each gives rvalid=1, err=1, rdata=0; word @0x04 is unchanged.
REQ-042 WAIT_CYC=3: load accepted in cycle N -> rvalid in cycle N+4 only; ready=0 in N+1..N+4; next accept possible in N+5.
REQ-043 Store accepted, rst pulsed before the RESP-entry edge -> no rvalid; after re-INIT the target word reads 0.
